// File: rtl/multi_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_clk_divider
// Purpose  : Generates NCH independent divided clocks from one system clock.
//            Each channel has a runtime-programmable half-period, a run
//            enable and an optional one-cycle tick strobe per output toggle.
//            Divisor writes go to a per-channel shadow register and are
//            loaded into the active divisor only at a period boundary (or
//            immediately while the channel is idle), so outputs never glitch.
// Ports    : clk        in   system clock, all logic on posedge
//            rst        in   asynchronous active-high reset
//            en         in   [NCH]   per-channel run enable
//            cfg_valid  in   divisor write request
//            cfg_ch     in   [3]     target channel (>= NCH: accepted, dropped)
//            cfg_div    in   [WIDTH] new half-period in clk cycles (0 -> 1)
//            cfg_ready  out  write can be accepted this cycle
//            clk_out    out  [NCH]   divided square waves, 50% duty
//            tick       out  [NCH]   one-cycle strobe per clk_out toggle
// Config   : define CLKDIV_TICK_EN to build the tick registers; otherwise
//            tick is tied low and clk_out behaviour is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module multi_clk_divider #(
  parameter int NCH         = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
  // A zero reset divisor would stall the counter compare; clamp it to 1.
  localparam logic [WIDTH-1:0] c_RESET_DIV = (DEFAULT_DIV == 0) ? c_ONE : WIDTH'(DEFAULT_DIV);

  logic [NCH-1:0]   pending;
  logic             cfg_accept;
  logic [WIDTH-1:0] cfg_div_sat;

  // Ready reflects only the addressed channel's pending flag; writes to a
  // channel index that does not exist are always accepted and discarded.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == 3'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  assign cfg_accept  = cfg_valid & cfg_ready;
  assign cfg_div_sat = (cfg_div == '0) ? c_ONE : cfg_div;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] active_div_q, active_div_d;
      logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
      logic             pending_q, pending_d;
      logic             clk_out_q, clk_out_d;
      logic             wrap;
      logic             wr_hit;

      assign wr_hit = cfg_accept && (cfg_ch == 3'(g));
      // active_div is never 0, so active_div-1 cannot underflow. The >=
      // keeps the compare safe even if cnt were ever past the terminal value.
      assign wrap   = en[g] && (cnt_q >= (active_div_q - c_ONE));

      always_comb begin
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        shadow_div_d = shadow_div_q;
        pending_d    = pending_q;
        clk_out_d    = clk_out_q;

        if (en[g]) begin
          if (wrap) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            if (pending_q) begin
              active_div_d = shadow_div_q;
              pending_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end else begin
          // Idle: park the output low and load any waiting divisor at once.
          cnt_d     = '0;
          clk_out_d = 1'b0;
          if (pending_q) begin
            active_div_d = shadow_div_q;
            pending_d    = 1'b0;
          end
        end

        // A hit implies pending_q was clear (ready gated it), so this never
        // overrides a load that is happening on the same edge.
        if (wr_hit) begin
          shadow_div_d = cfg_div_sat;
          pending_d    = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q        <= '0;
          active_div_q <= c_RESET_DIV;
          shadow_div_q <= c_RESET_DIV;
          pending_q    <= 1'b0;
          clk_out_q    <= 1'b0;
        end else begin
          cnt_q        <= cnt_d;
          active_div_q <= active_div_d;
          shadow_div_q <= shadow_div_d;
          pending_q    <= pending_d;
          clk_out_q    <= clk_out_d;
        end
      end

      assign clk_out[g] = clk_out_q;
      assign pending[g] = pending_q;

`ifdef CLKDIV_TICK_EN
      logic tick_q, tick_d;

      // Registered on the same edge as the clk_out toggle it marks.
      always_comb begin
        tick_d = wrap;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tick_q <= 1'b0;
        end else begin
          tick_q <= tick_d;
        end
      end

      assign tick[g] = tick_q;
`else
      assign tick[g] = 1'b0;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_clk_divider
// Purpose  : Directed bench for multi_clk_divider (NCH=2, WIDTH=8,
//            DEFAULT_DIV=4). Stimulus pushes hand-computed expectations,
//            tagged with the absolute posedge count at which they hold, into
//            a scoreboard queue; an independent monitor samples the outputs
//            on every negedge and retires the entries due that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_clk_divider;

  localparam int NCH   = 2;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic [2:0]       cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  multi_clk_divider #(
    .NCH        (NCH),
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute posedge counter; never reset, so expectations survive rst.
  int t = 0;
  always @(posedge clk) t <= t + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] co;
    logic [1:0] tk;
    logic       rd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   base  = 0;

  function automatic logic [1:0] tk(input logic [1:0] v);
`ifdef CLKDIV_TICK_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  // Expectation for the state seen at the negedge following posedge base+n.
  task automatic expb(input int n, input string nm, input logic [1:0] co,
                      input logic [1:0] tkv, input logic rd);
    exp_t e;
    e.cyc = base + n;
    e.nm  = nm;
    e.co  = co;
    e.tk  = tk(tkv);
    e.rd  = rd;
    q.push_back(e);
  endtask

  // Advance to just after the negedge that follows posedge base+n.
  task automatic at(input int n);
    while (t < base + n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: retire every scoreboard entry due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= t) begin
          total++;
          if (q[i].cyc < t) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", q[i].nm, q[i].cyc, t);
          end else if ({clk_out, tick, cfg_ready} !== {q[i].co, q[i].tk, q[i].rd}) begin
            bad++;
            $display("FAIL %s @%0d: got clk_out=%b tick=%b ready=%b, want clk_out=%b tick=%b ready=%b",
                     q[i].nm, t, clk_out, tick, cfg_ready, q[i].co, q[i].tk, q[i].rd);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    en        = 2'b11;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_div   = '0;

    repeat (3) @(negedge clk);
    #1;
    base = t;
    expb(1, "reset_state", 2'b00, 2'b00, 1'b1);
    @(negedge clk);
    #1;

    rst  = 1'b0;
    base = t;

    // Default divisor 4, then ch0 retimed to 2 by a write accepted at 5.
    expb(3,  "pre_first_toggle",   2'b00, 2'b00, 1'b1);
    expb(4,  "first_rise",         2'b11, 2'b11, 1'b1);
    expb(5,  "after_accept",       2'b11, 2'b00, 1'b0);
    expb(7,  "pending_held",       2'b11, 2'b00, 1'b0);
    expb(8,  "first_fall_load",    2'b00, 2'b11, 1'b1);
    expb(9,  "new_div_counting",   2'b00, 2'b00, 1'b1);
    expb(10, "ch0_div2_rise",      2'b01, 2'b01, 1'b1);
    expb(12, "ch0_fall_ch1_rise",  2'b10, 2'b11, 1'b1);
    expb(14, "ch0_div2_rise2",     2'b11, 2'b01, 1'b1);
    expb(16, "both_fall",          2'b00, 2'b11, 1'b1);
    // Back-to-back writes to ch0 (3 then 5) with cfg_valid held.
    expb(17, "wr3_pending",        2'b00, 2'b00, 1'b0);
    expb(18, "wr3_loaded",         2'b01, 2'b01, 1'b1);
    expb(19, "wr5_accepted",       2'b01, 2'b00, 1'b0);
    expb(20, "div3_no_toggle",     2'b11, 2'b10, 1'b0);
    expb(21, "div3_fall_load5",    2'b10, 2'b01, 1'b1);
    expb(24, "div5_no_toggle",     2'b00, 2'b10, 1'b1);
    expb(25, "div5_quiet",         2'b00, 2'b00, 1'b1);
    expb(26, "div5_rise",          2'b01, 2'b01, 1'b1);
    // ch1 disabled, written with 0 (stored as 1), then re-enabled.
    expb(27, "idle_wr_pending",    2'b01, 2'b00, 1'b0);
    expb(28, "idle_load",          2'b01, 2'b00, 1'b1);
    expb(29, "div1_rise",          2'b11, 2'b10, 1'b1);
    expb(30, "div1_fall",          2'b01, 2'b10, 1'b1);
    expb(31, "div1_rise_ch0_fall", 2'b10, 2'b11, 1'b1);
    expb(32, "div1_fall2",         2'b00, 2'b10, 1'b1);
    // Write to nonexistent channel 5.
    expb(33, "ch5_ready",          2'b10, 2'b10, 1'b1);
    expb(34, "ch5_ch0_untouched",  2'b00, 2'b10, 1'b1);
    expb(35, "ch5_ch1_untouched",  2'b10, 2'b10, 1'b1);
    expb(36, "ch5_phases_kept",    2'b01, 2'b11, 1'b1);
    expb(37, "pre_reset_run",      2'b11, 2'b10, 1'b1);
    expb(38, "pre_reset_pending",  2'b01, 2'b10, 1'b0);
    // Async reset asserted between posedge 39 and its negedge.
    expb(39, "async_reset_now",    2'b00, 2'b00, 1'b1);
    expb(40, "reset_held",         2'b00, 2'b00, 1'b1);

    at(4);  cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
    at(5);  cfg_valid = 1'b0;
    at(16); cfg_valid = 1'b1; cfg_div = 8'd3;
    at(17); cfg_div = 8'd5;
    at(19); cfg_valid = 1'b0;
    at(26); en = 2'b01; cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0;
    at(27); cfg_valid = 1'b0;
    at(28); en = 2'b11;
    at(32); cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd7;
    at(33); cfg_valid = 1'b0; cfg_ch = 3'd0;
    at(34); cfg_ch = 3'd1;
    at(37); cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
    at(38); cfg_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    at(40);
    rst  = 1'b0;
    base = t;

    // After reset: default period again, the pending 3 must be gone.
    expb(3, "post_reset_quiet", 2'b00, 2'b00, 1'b1);
    expb(4, "post_reset_rise",  2'b11, 2'b11, 1'b1);
    expb(7, "post_reset_held",  2'b11, 2'b00, 1'b1);
    expb(8, "post_reset_fall",  2'b00, 2'b11, 1'b1);

    at(9);

    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: expectation for cycle %0d never checked", q[0].nm, q[0].cyc);
      void'(q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_clk_divider.md
# multi_clk_divider

- Parametrised successor to the single-output fixed divider.
- Generates NCH independent divided clocks from one system clock. Each channel has a runtime-programmable divisor, a per-channel enable, and an optional one-cycle tick strobe.
- Sits between the board clock and the vending-machine FSM, display multiplexer and timeout logic, which each need their own slow rate.
- Divisor updates are glitch-free: they are applied only at a period boundary.

## Interface
Parameters:
- NCH, 2: number of output channels (1..8).
- WIDTH, 32: divisor and counter width.
- DEFAULT_DIV, 50000000: divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  3  target channel index.
- cfg_div  in  WIDTH  new half-period in clk cycles.
- cfg_ready  out  1  write can be accepted this cycle.
- clk_out  out  NCH  divided square-wave outputs.
- tick  out  NCH  one-cycle strobe on each clk_out toggle.

## Operation
- Per-channel state:
  - cnt[WIDTH]
  - active_div[WIDTH]
  - shadow_div[WIDTH]
  - pending flag
  - clk_out register
- Channel run state (en=1): each clk increments cnt. When cnt == active_div-1:
  - clk_out toggles.
  - cnt returns to 0.
  - If pending: active_div <= shadow_div and pending clears.
- Output period = 2*active_div cycles, 50% duty.
- Channel idle state (en=0): on the next edge, cnt <= 0 and clk_out <= 0.
  - If pending, active_div <= shadow_div and pending clears (immediate load while idle).
- Rising en: counting starts from cnt=0 with clk_out=0.
- Write handshake:
  - A write is accepted on an edge where cfg_valid & cfg_ready.
  - cfg_ready = ~pending[cfg_ch]; combinational from the registered pending and the current cfg_ch.
  - On accept: shadow_div[cfg_ch] <= cfg_div and pending set.
  - cfg_ch >= NCH: cfg_ready=1, the write is accepted and discarded; no state changes.
- cfg_div == 0 is stored as 1, so no channel can stall.
- Simultaneous accept and wrap on the same channel: the wrap uses the old shadow value if one was pending. Accept is blocked in that case, because cfg_ready=0 while pending. The new value sets pending and applies at the following wrap.
- Channels are fully independent. A write to one channel never disturbs another channel's phase.

## Timing
- Reset values:
  - cnt=0
  - active_div=shadow_div=DEFAULT_DIV
  - pending=0
  - clk_out=0
  - tick=0
  - cfg_ready=1
- Reset is asynchronous: asserting rst mid-period forces all outputs low immediately and discards pending writes.
- First toggle: with en held high from cycle 0 and divisor D, clk_out rises at the D-th posedge and falls at the 2D-th.
- tick is high for exactly the one cycle following each toggle edge, i.e. registered on the same edge as clk_out.
- Divisor change latency:
  - Enabled channel: effective from the first wrap after accept; the current half-period always completes with the old value.
  - Disabled channel: active one cycle after accept.
- cfg_ready deasserts the cycle after accept and reasserts the cycle after the load.

## Configuration
- Macro: CLKDIV_TICK_EN.
- Defined: tick outputs are driven as described above.
- Undefined: tick is tied to 0, its registers are not built, and clk_out behaviour is identical.

## Test plan
- Reset, NCH=2, DEFAULT_DIV=4, en=2'b11 -> both clk_out rise at posedge 4 and fall at posedge 8; tick pulses at posedges 4, 8, 12.
- Channel 0 running at D=4; write cfg_div=2 at cycle 5 -> the current half-period ends at posedge 8, then toggles at 10, 12; cfg_ready low from cycle 6 until after posedge 8.
- Second write to channel 0 while pending -> cfg_ready=0; holding cfg_valid, the write is accepted the cycle after the load and applies at the next wrap.
- en[1]=0, write cfg_div=0 to channel 1, then en[1]=1 -> active_div=1, and clk_out[1] toggles every cycle.
- Write with cfg_ch=5 -> accepted (cfg_ready=1), and both channels' divisors and phases are unchanged.
- Assert rst asynchronously mid-period with a pending write -> clk_out=0 and tick=0 immediately; after release, the period returns to 2*DEFAULT_DIV and the pending write is lost.
